// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup and memory-side resolve signals of the branch target buffer.
// The master side is the pipeline/next-PC logic; the slave side is the buffer.
interface branch_target_buffer_if;
  logic        flushD;
  logic        stallD;
  logic        flushE;
  logic        flushM;
  logic [31:0] pcF;
  logic        branchF;
  logic [31:0] targetF;
  logic [31:0] pcM;
  logic        branchM;
  logic        actual_takeM;
  logic [31:0] actual_targetM;
  logic        hitM;
  logic [31:0] pred_targetM;
  logic        target_missM;

  modport master (
    output flushD, stallD, flushE, flushM,
    output pcF, pcM, branchM, actual_takeM, actual_targetM,
    input  branchF, targetF, hitM, pred_targetM, target_missM
  );

  modport slave (
    input  flushD, stallD, flushE, flushM,
    input  pcF, pcM, branchM, actual_takeM, actual_targetM,
    output branchF, targetF, hitM, pred_targetM, target_missM
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup at F, hit/target
// carried F->D->E->M, entry install/invalidate from resolved outcomes at M.
module branch_target_buffer #(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_BITS = 8
) (
  input logic                 clk,
  input logic                 rst,
  branch_target_buffer_if.slave bus
);
  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  typedef struct packed {
    logic        hit;
    logic [31:0] target;
  } carry_t;

  logic [ENTRIES-1:0]  valid;
  logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
  logic [29:0]         target_mem [ENTRIES];

  logic [IDX_BITS-1:0] idx_f;
  logic [IDX_BITS-1:0] idx_m;
  logic [TAG_BITS-1:0] tag_f;
  logic [TAG_BITS-1:0] tag_m;
  logic                hit_f;
  carry_t              stage_f;
  carry_t              stage_d;
  carry_t              stage_e;
  carry_t              stage_m;
  logic                unused_bits;

  // Index/tag extraction and lookup from current contents (no write bypass).
  always_comb begin
    idx_f   = bus.pcF[IDX_BITS+1:2];
    tag_f   = bus.pcF[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    idx_m   = bus.pcM[IDX_BITS+1:2];
    tag_m   = bus.pcM[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    hit_f   = valid[idx_f] && (tag_mem[idx_f] == tag_f);
    stage_f = '0;
    if (hit_f) begin
      stage_f.hit    = 1'b1;
      stage_f.target = {target_mem[idx_f], 2'b00};
    end
  end

  // Valid bits: reset clears, taken branch installs, stale non-branch hit clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (bus.branchM && bus.actual_takeM) begin
      valid[idx_m] <= 1'b1;
    end else if (!bus.branchM && stage_m.hit && (tag_mem[idx_m] == tag_m)) begin
      valid[idx_m] <= 1'b0;
    end
  end

  // Tag/target payload: written on every taken branch, contents unreset.
  always_ff @(posedge clk) begin
    if (!rst && bus.branchM && bus.actual_takeM) begin
      tag_mem[idx_m]    <= tag_m;
      target_mem[idx_m] <= bus.actual_targetM[31:2];
    end
  end

  // F->D carry register: flushD wins over stallD.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_d <= '0;
    end else if (bus.flushD) begin
      stage_d <= '0;
    end else if (!bus.stallD) begin
      stage_d <= stage_f;
    end
  end

  // D->E carry register, always enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_e <= '0;
    end else if (bus.flushE) begin
      stage_e <= '0;
    end else begin
      stage_e <= stage_d;
    end
  end

  // E->M carry register, always enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_m <= '0;
    end else if (bus.flushM) begin
      stage_m <= '0;
    end else begin
      stage_m <= stage_e;
    end
  end

  // Outputs; target miss only for taken branches (direction errors are not ours).
  always_comb begin
    bus.branchF      = hit_f;
    bus.targetF      = stage_f.target;
    bus.hitM         = stage_m.hit;
    bus.pred_targetM = stage_m.target;
    bus.target_missM = bus.branchM && bus.actual_takeM &&
                       (!stage_m.hit || (stage_m.target[31:2] != bus.actual_targetM[31:2]));
  end

  // PC bits outside index/tag and target byte offset do not participate.
  assign unused_bits = ^{bus.pcF, bus.pcM, bus.actual_targetM[1:0]};
endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed scenarios plus randomized traffic
// against an array/record model of entries and the F->M carry pipeline.
module tb_branch_target_buffer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  branch_target_buffer_if bus ();

  branch_target_buffer #(.IDX_BITS(6), .TAG_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    bit        hit;
    bit [31:0] tgt;
  } rec_t;

  bit        m_valid [64];
  bit [7:0]  m_tag   [64];
  bit [31:0] m_tgt   [64];
  rec_t      rd, re, rm;

  function automatic int idx_of(bit [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic bit [7:0] tag_of(bit [31:0] pc);
    return 8'((pc / 256) % 256);
  endfunction

  function automatic bit exp_branchF();
    int i;
    i = idx_of(bus.pcF);
    return m_valid[i] && (m_tag[i] == tag_of(bus.pcF));
  endfunction

  function automatic bit [31:0] exp_targetF();
    if (!exp_branchF()) return 32'h0;
    return m_tgt[idx_of(bus.pcF)];
  endfunction

  function automatic bit exp_miss();
    if (!(bus.branchM && bus.actual_takeM)) return 1'b0;
    if (!rm.hit) return 1'b1;
    return (rm.tgt / 4) != (bus.actual_targetM / 4);
  endfunction

  task automatic model_edge();
    rec_t fetched;
    int   im;
    fetched.hit = exp_branchF();
    fetched.tgt = exp_targetF();
    if (rst) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      rd = '0; re = '0; rm = '0;
      return;
    end
    im = idx_of(bus.pcM);
    if (bus.branchM && bus.actual_takeM) begin
      m_valid[im] = 1'b1;
      m_tag[im]   = tag_of(bus.pcM);
      m_tgt[im]   = bus.actual_targetM & 32'hFFFF_FFFC;
    end else if (!bus.branchM && rm.hit && m_valid[im] && m_tag[im] == tag_of(bus.pcM)) begin
      m_valid[im] = 1'b0;
    end
    rm = bus.flushM ? '0 : re;
    re = bus.flushE ? '0 : rd;
    if (bus.flushD) rd = '0;
    else if (!bus.stallD) rd = fetched;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.flushD = 0; bus.stallD = 0; bus.flushE = 0; bus.flushM = 0;
    bus.pcM = 32'h0; bus.branchM = 0; bus.actual_takeM = 0; bus.actual_targetM = 32'h0;
  endtask

  task automatic drain();
    bus.pcF = 32'h0050_0000;
    for (int i = 0; i < 3; i++) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    bus.pcF = 32'h0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      bus.pcF = 32'h0040_0000 + 32'(i * 4);
      #2;
      checks++;
      if (bus.branchF !== 1'b0 || bus.targetF !== 32'h0) begin
        errors++;
        $display("FAIL reset_lookup idx=%0d branchF=%b targetF=%h required 0/0", i, bus.branchF, bus.targetF);
      end
      checks++;
      if (bus.hitM !== 1'b0 || bus.target_missM !== 1'b0) begin
        errors++;
        $display("FAIL reset_m idx=%0d hitM=%b target_missM=%b required 0/0", i, bus.hitM, bus.target_missM);
      end
      tick();
    end
  endtask

  task automatic test_install();
    bus.pcF = 32'h0040_0010;
    bus.pcM = 32'h0040_0010; bus.branchM = 1; bus.actual_takeM = 1;
    bus.actual_targetM = 32'h0040_0040;
    #2;
    checks++;
    if (bus.target_missM !== 1'b1) begin
      errors++; $display("FAIL install_miss target_missM=%b required 1", bus.target_missM);
    end
    checks++;
    if (bus.branchF !== 1'b0) begin
      errors++; $display("FAIL same_cycle_lookup branchF=%b required 0", bus.branchF);
    end
    tick();
    idle_inputs();
    #2;
    checks++;
    if (bus.branchF !== 1'b1 || bus.targetF !== 32'h0040_0040) begin
      errors++;
      $display("FAIL install_hit branchF=%b targetF=%h required 1/00400040", bus.branchF, bus.targetF);
    end
    tick();
  endtask

  task automatic test_alias_retention();
    bus.pcF = 32'h0040_1010;
    #2;
    checks++;
    if (bus.branchF !== 1'b0) begin
      errors++; $display("FAIL alias_tag branchF=%b required 0", bus.branchF);
    end
    bus.pcM = 32'h0040_0010; bus.branchM = 1; bus.actual_takeM = 0;
    bus.actual_targetM = 32'h0040_0100;
    tick();
    idle_inputs();
    bus.pcF = 32'h0040_0010;
    #2;
    checks++;
    if (bus.branchF !== 1'b1 || bus.targetF !== 32'h0040_0040) begin
      errors++;
      $display("FAIL not_taken_keeps branchF=%b targetF=%h required 1/00400040", bus.branchF, bus.targetF);
    end
    tick();
  endtask

  task automatic test_invalidate();
    drain();
    bus.pcF = 32'h0040_0010;
    #2;
    checks++;
    if (bus.branchF !== 1'b1) begin
      errors++; $display("FAIL inval_pre_hit branchF=%b required 1", bus.branchF);
    end
    tick();
    bus.pcF = 32'h0050_0000;
    tick();
    tick();
    bus.pcM = 32'h0040_0010; bus.branchM = 0;
    #2;
    checks++;
    if (bus.hitM !== 1'b1) begin
      errors++; $display("FAIL inval_hitM hitM=%b required 1", bus.hitM);
    end
    tick();
    idle_inputs();
    bus.pcF = 32'h0040_0010;
    #2;
    checks++;
    if (bus.branchF !== 1'b0) begin
      errors++; $display("FAIL inval_cleared branchF=%b required 0", bus.branchF);
    end
    tick();
  endtask

  task automatic reinstall(input bit [31:0] tgt);
    bus.pcF = 32'h0050_0000;
    bus.pcM = 32'h0040_0010; bus.branchM = 1; bus.actual_takeM = 1; bus.actual_targetM = tgt;
    tick();
    idle_inputs();
  endtask

  task automatic test_stall();
    drain();
    reinstall(32'h0040_0040);
    bus.pcF = 32'h0040_0010;
    tick();
    bus.stallD = 1; bus.pcF = 32'h0050_0000;
    tick();
    tick();
    bus.stallD = 0;
    tick();
    tick();
    #2;
    checks++;
    if (bus.hitM !== 1'b1 || bus.pred_targetM !== 32'h0040_0040) begin
      errors++;
      $display("FAIL stall_hold hitM=%b pred_targetM=%h required 1/00400040", bus.hitM, bus.pred_targetM);
    end
    checks++;
    if (bus.hitM !== rm.hit) begin
      errors++; $display("FAIL stall_model hitM=%b required %b", bus.hitM, rm.hit);
    end
  endtask

  task automatic test_flushE();
    drain();
    bus.pcF = 32'h0040_0010;
    tick();
    bus.flushE = 1; bus.pcF = 32'h0050_0000;
    tick();
    bus.flushE = 0;
    tick();
    #2;
    checks++;
    if (bus.hitM !== 1'b0 || bus.pred_targetM !== 32'h0) begin
      errors++;
      $display("FAIL flushE hitM=%b pred_targetM=%h required 0/0", bus.hitM, bus.pred_targetM);
    end
  endtask

  task automatic test_target_mismatch();
    drain();
    bus.pcF = 32'h0040_0010;
    tick();
    bus.pcF = 32'h0050_0000;
    tick();
    tick();
    bus.pcM = 32'h0040_0010; bus.branchM = 1; bus.actual_takeM = 1;
    bus.actual_targetM = 32'h0040_0080;
    #2;
    checks++;
    if (bus.hitM !== 1'b1 || bus.target_missM !== 1'b1) begin
      errors++;
      $display("FAIL wrong_target hitM=%b target_missM=%b required 1/1", bus.hitM, bus.target_missM);
    end
    tick();
    idle_inputs();
    bus.pcF = 32'h0040_0010;
    #2;
    checks++;
    if (bus.targetF !== 32'h0040_0080) begin
      errors++; $display("FAIL retarget targetF=%h required 00400080", bus.targetF);
    end
    tick();
    bus.pcF = 32'h0050_0000;
    tick();
    tick();
    bus.pcM = 32'h0040_0010; bus.branchM = 1; bus.actual_takeM = 1;
    bus.actual_targetM = 32'h0040_0083;
    #2;
    checks++;
    if (bus.target_missM !== 1'b0) begin
      errors++; $display("FAIL right_target target_missM=%b required 0", bus.target_missM);
    end
    tick();
    idle_inputs();
  endtask

  function automatic bit [31:0] rand_pc();
    bit [31:0] pc;
    pc = 32'h0040_0000;
    pc = pc | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
    pc = pc | (32'($urandom_range(0, 1)) << 20) | 32'($urandom_range(0, 3));
    return pc;
  endfunction

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      rst                = ($urandom_range(0, 63) == 0);
      bus.pcF            = rand_pc();
      bus.pcM            = rand_pc();
      bus.branchM        = ($urandom_range(0, 1) == 1);
      bus.actual_takeM   = ($urandom_range(0, 3) != 0);
      bus.actual_targetM = 32'h0040_0000 + 32'($urandom_range(0, 7) * 64) + 32'($urandom_range(0, 3));
      bus.stallD         = ($urandom_range(0, 7) == 0);
      bus.flushD         = ($urandom_range(0, 9) == 0);
      bus.flushE         = ($urandom_range(0, 9) == 0);
      bus.flushM         = ($urandom_range(0, 9) == 0);
      #2;
      checks++;
      if (bus.branchF !== exp_branchF() || bus.targetF !== exp_targetF()) begin
        errors++;
        $display("FAIL rand_F cyc=%0d pcF=%h branchF=%b targetF=%h required %b/%h",
                 n, bus.pcF, bus.branchF, bus.targetF, exp_branchF(), exp_targetF());
      end
      checks++;
      if (bus.hitM !== rm.hit || bus.pred_targetM !== rm.tgt) begin
        errors++;
        $display("FAIL rand_M cyc=%0d hitM=%b pred_targetM=%h required %b/%h",
                 n, bus.hitM, bus.pred_targetM, rm.hit, rm.tgt);
      end
      checks++;
      if (bus.target_missM !== exp_miss()) begin
        errors++;
        $display("FAIL rand_miss cyc=%0d target_missM=%b required %b", n, bus.target_missM, exp_miss());
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    bus.pcF = 32'h0;
    #1;
    test_reset();
    test_install();
    test_alias_retention();
    test_invalidate();
    test_stall();
    test_flushE();
    test_target_mismatch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
